// File: rtl/ras_predictor.sv
// ras_predictor: return address stack with speculative pointer repair on D/E mispredictions
module ras_predictor #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     StallF,
  input  logic                     StallD,
  input  logic                     StallE,
  input  logic                     FlushD,
  input  logic                     FlushM,
  input  logic                     BPReturnF,
  input  logic                     ReturnD,
  input  logic                     BPReturnWrongD,
  input  logic                     BPWrongE,
  input  logic                     CallE,
  input  logic [XLEN-1:0]          PCLinkE,
  output logic [XLEN-1:0]          RASPCF,
  output logic [$clog2(DEPTH):0]   RASCount
);
  localparam int AW = $clog2(DEPTH);
  logic [XLEN-1:0] stack_q [DEPTH];
  logic [AW-1:0]   ptr_q, ptr_d, wr_idx;
  logic            popd_q, popd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [AW+1:0]   cnt_up, cnt_dn, cnt_net;
  logic            push, pop_f, undo_d, late_d, wrong_e;
  assign wrong_e = BPWrongE & ~StallE;
  assign push    = CallE & ~StallE & ~FlushM;
  assign pop_f   = BPReturnF & ~StallF & ~FlushD;
  assign undo_d  = ~StallD & popd_q & (wrong_e | (BPReturnWrongD & ~ReturnD));
  // an E-stage redirect squashes D, so a D-stage class mismatch must not pop
  assign late_d  = ~StallD & ~popd_q & ReturnD & BPReturnWrongD & ~wrong_e;
  always_comb begin
    ptr_d   = ptr_q + AW'(push) - AW'(pop_f) + AW'(undo_d) - AW'(late_d);
    wr_idx  = ptr_q + AW'(1) + AW'(undo_d);
    popd_d  = FlushD ? 1'b0 : StallD ? popd_q : pop_f;
    cnt_up  = {1'b0, cnt_q} + (AW+2)'(push) + (AW+2)'(undo_d);
    cnt_dn  = (AW+2)'(pop_f) + (AW+2)'(late_d);
    cnt_net = cnt_up - cnt_dn;
    cnt_d   = cnt_up < cnt_dn ? '0 :
              cnt_net > (AW+2)'(DEPTH) ? (AW+1)'(DEPTH) : cnt_net[AW:0];
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      popd_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      popd_q <= popd_d;
      cnt_q  <= cnt_d;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[wr_idx] <= PCLinkE;
    end
  end
  assign RASPCF   = push ? PCLinkE : stack_q[ptr_q];
  assign RASCount = cnt_q;
endmodule

// File: tb/tb_ras_predictor.sv
// tb_ras_predictor: directed vector table plus random traffic against a circular-buffer model
module tb_ras_predictor;
  localparam int XLEN = 32;
  localparam int D    = 4;
  localparam logic [9:0] SF = 10'h001, SD = 10'h002, SE = 10'h004, FD = 10'h008, FM = 10'h010,
                         BPR = 10'h020, RD = 10'h040, BPRW = 10'h080, BPWE = 10'h100, CALL = 10'h200;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n = 1'b1;
  logic StallF = 0, StallD = 0, StallE = 0, FlushD = 0, FlushM = 0;
  logic BPReturnF = 0, ReturnD = 0, BPReturnWrongD = 0, BPWrongE = 0, CallE = 0;
  logic [XLEN-1:0] PCLinkE = '0;
  logic [XLEN-1:0] RASPCF;
  logic [2:0]      RASCount;
  ras_predictor #(.XLEN(XLEN), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushM(FlushM), .BPReturnF(BPReturnF), .ReturnD(ReturnD),
    .BPReturnWrongD(BPReturnWrongD), .BPWrongE(BPWrongE), .CallE(CallE),
    .PCLinkE(PCLinkE), .RASPCF(RASPCF), .RASCount(RASCount)
  );
  int checks = 0, errors = 0;
  logic [XLEN-1:0] m_stack [D];
  int m_ptr, m_cnt;
  bit m_popd;
  typedef struct {
    bit rst;
    logic [9:0] ctl;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] pc;
    int cnt;
  } vec_t;
  vec_t vecs [$];
  function automatic vec_t v(bit rst, logic [9:0] ctl, logic [XLEN-1:0] link, logic [XLEN-1:0] pc, int cnt);
    vec_t r;
    r.rst = rst; r.ctl = ctl; r.link = link; r.pc = pc; r.cnt = cnt;
    return r;
  endfunction
  task automatic chk(string name, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < D; i++) m_stack[i] = '0;
    m_ptr = 0; m_cnt = 0; m_popd = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    CallE = 1; PCLinkE = 32'hdead_beef;
    #1 reset_n = 0;
    #1 chk("rst_async_cnt", 32'(RASCount), 32'd0);
    model_reset();
    @(negedge clk);
    CallE = 0; reset_n = 1;
  endtask
  task automatic step(logic [9:0] c, logic [XLEN-1:0] link, bit has_exp, logic [XLEN-1:0] epc, int ecnt);
    bit push, pop, undo, late, we;
    logic [XLEN-1:0] mpc;
    int idx, n;
    @(negedge clk);
    {CallE, BPWrongE, BPReturnWrongD, ReturnD, BPReturnF, FlushM, FlushD, StallE, StallD, StallF} = c;
    PCLinkE = link;
    #1;
    we   = BPWrongE & ~StallE;
    push = CallE & ~StallE & ~FlushM;
    pop  = BPReturnF & ~StallF & ~FlushD;
    undo = ~StallD & m_popd & (we | (BPReturnWrongD & ~ReturnD));
    late = ~StallD & ~m_popd & ReturnD & BPReturnWrongD & ~we;
    mpc  = push ? link : m_stack[m_ptr];
    if (has_exp) begin
      chk("tbl_pc", RASPCF, epc);
      chk("tbl_cnt", 32'(RASCount), 32'(ecnt));
    end
    chk("mdl_pc", RASPCF, mpc);
    chk("mdl_cnt", 32'(RASCount), 32'(m_cnt));
    @(posedge clk);
    idx = (m_ptr + 1 + int'(undo)) % D;
    if (push) m_stack[idx] = link;
    m_ptr = (m_ptr + int'(push) - int'(pop) + int'(undo) - int'(late) + 2 * D) % D;
    n = m_cnt + int'(push) + int'(undo) - int'(pop) - int'(late);
    m_cnt = n < 0 ? 0 : n > D ? D : n;
    m_popd = FlushD ? 1'b0 : StallD ? m_popd : pop;
  endtask
  initial begin
    vecs.push_back(v(1, 0, 0, 0, 0));
    // fill past capacity, then pop through the wrap
    vecs.push_back(v(0, CALL, 32'h100, 32'h100, 0));
    vecs.push_back(v(0, CALL, 32'h200, 32'h200, 1));
    vecs.push_back(v(0, CALL, 32'h300, 32'h300, 2));
    vecs.push_back(v(0, CALL, 32'h400, 32'h400, 3));
    vecs.push_back(v(0, CALL, 32'h500, 32'h500, 4));
    vecs.push_back(v(0, BPR, 0, 32'h500, 4));
    vecs.push_back(v(0, BPR, 0, 32'h400, 3));
    vecs.push_back(v(0, BPR, 0, 32'h300, 2));
    vecs.push_back(v(0, BPR, 0, 32'h200, 1));
    vecs.push_back(v(0, BPR, 0, 32'h500, 0));
    vecs.push_back(v(0, 0, 0, 32'h400, 0));
    // same-cycle push/pop, then undo the pop to expose the written slot
    vecs.push_back(v(0, CALL | BPR, 32'h1234, 32'h1234, 0));
    vecs.push_back(v(0, BPWE | FD, 0, 32'h400, 0));
    vecs.push_back(v(0, 0, 0, 32'h1234, 1));
    // reset mid-push wipes every entry
    vecs.push_back(v(1, BPR, 0, 0, 0));
    vecs.push_back(v(0, BPR, 0, 0, 0));
    vecs.push_back(v(0, BPR, 0, 0, 0));
    vecs.push_back(v(0, BPR, 0, 0, 0));
    vecs.push_back(v(0, 0, 0, 0, 0));
    // E-stage undo
    vecs.push_back(v(0, CALL, 32'hA0, 32'hA0, 0));
    vecs.push_back(v(0, CALL, 32'hB0, 32'hB0, 1));
    vecs.push_back(v(0, BPR, 0, 32'hB0, 2));
    vecs.push_back(v(0, BPWE | FD, 0, 32'hA0, 1));
    vecs.push_back(v(0, BPR, 0, 32'hB0, 2));
    // D-stage false return then unpredicted return
    vecs.push_back(v(0, BPRW, 0, 32'hA0, 1));
    vecs.push_back(v(0, 0, 0, 32'hB0, 2));
    vecs.push_back(v(0, RD | BPRW, 0, 32'hB0, 2));
    vecs.push_back(v(0, 0, 0, 32'hA0, 1));
    // repair held off by StallD, then applied once
    vecs.push_back(v(0, BPR, 0, 32'hA0, 1));
    vecs.push_back(v(0, SD | BPRW, 0, 32'h0, 0));
    vecs.push_back(v(0, SD | BPRW, 0, 32'h0, 0));
    vecs.push_back(v(0, SD | BPRW, 0, 32'h0, 0));
    vecs.push_back(v(0, BPRW, 0, 32'h0, 0));
    vecs.push_back(v(0, BPRW, 0, 32'hA0, 1));
    vecs.push_back(v(0, 0, 0, 32'hA0, 1));
    model_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      step(vecs[i].ctl, vecs[i].link, 1'b1, vecs[i].pc, vecs[i].cnt);
    end
    for (int k = 0; k < 400; k++) begin
      logic [9:0] c;
      c = '0;
      if ($urandom_range(99) < 12) c |= SF;
      if ($urandom_range(99) < 12) c |= SD;
      if ($urandom_range(99) < 12) c |= SE;
      if ($urandom_range(99) < 10) c |= FD;
      if ($urandom_range(99) < 8)  c |= FM;
      if ($urandom_range(99) < 40) c |= BPR;
      if ($urandom_range(99) < 25) c |= RD;
      if ($urandom_range(99) < 25) c |= BPRW;
      if ($urandom_range(99) < 15) c |= BPWE;
      if ($urandom_range(99) < 40) c |= CALL;
      if (k == 200) do_reset();
      step(c, $urandom, 1'b0, '0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
